// File: rtl/attn_pipe_ctrl_pkg.sv
// Shared attention-pipeline definitions: stage count, stage indices, latency defaults
// and helpers for sizing the per-stage latency counters.
package attn_pipe_ctrl_pkg;

    localparam int NUM_STAGES    = 3;

    // Stage indices, also the bit positions in stage_en / stage_busy
    localparam int STG_QK        = 0;
    localparam int STG_SM        = 1;
    localparam int STG_SV        = 2;

    localparam int LAT_QK_DEF    = 1;
    localparam int LAT_SM_DEF    = 4;
    localparam int LAT_SV_DEF    = 1;
    localparam int CNT_WIDTH_DEF = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One extra bit over clog2 keeps LAT-1 representable for every LAT, including 1
    function automatic int lat_cnt_width(input int max_lat);
        return $clog2(max_lat) + 1;
    endfunction

endpackage

// File: rtl/attn_pipe_ctrl_stage_slot.sv
// One pipeline stage slot: occupied bit plus a down-counter of remaining compute cycles.
// The slot only tracks timing; when to leave is decided by the controller.
module attn_stage_slot #(
    parameter int LAT = 1,
    parameter int CW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_adv,
    output logic o_busy,
    output logic o_done
);

    logic          r_occ;
    logic [CW-1:0] r_cnt;
    logic          w_occ_d;
    logic [CW-1:0] w_cnt_d;

    // Next state: a load wins over a departure so back-to-back jobs keep the slot occupied
    always_comb begin
        w_occ_d = r_occ;
        w_cnt_d = r_cnt;
        if (r_cnt != '0) begin
            w_cnt_d = r_cnt - CW'(1);
        end
        if (i_load) begin
            w_occ_d = 1'b1;
            w_cnt_d = CW'(LAT - 1);
        end else if (i_adv) begin
            w_occ_d = 1'b0;
        end
    end

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_occ <= w_occ_d;
            r_cnt <= w_cnt_d;
        end
    end

    assign o_busy = r_occ;
    assign o_done = r_occ && (r_cnt == '0);

endmodule

// File: rtl/attn_pipe_ctrl.sv
// Three-stage attention pipeline controller (QK matmul -> softmax -> SV matmul).
// Each stage holds one job; jobs move forward with zero-bubble pass-through and
// stall in place under downstream backpressure.
module attn_pipe_ctrl
    import attn_pipe_ctrl_pkg::*;
#(
    parameter int LAT_QK    = LAT_QK_DEF,
    parameter int LAT_SM    = LAT_SM_DEF,
    parameter int LAT_SV    = LAT_SV_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_busy,
    output logic [CNT_WIDTH-1:0]  job_cnt,
    output logic                  idle
);

    localparam int CW = lat_cnt_width(max3(LAT_QK, LAT_SM, LAT_SV));

    if (LAT_QK < 1 || LAT_SM < 1 || LAT_SV < 1) begin : g_lat_check
        $error("attn_pipe_ctrl: every stage latency must be at least 1");
    end

    logic [NUM_STAGES-1:0] w_busy;
    logic [NUM_STAGES-1:0] w_done;
    logic [NUM_STAGES-1:0] w_adv;
    logic                  w_accept;
    logic [CNT_WIDTH-1:0]  r_job_cnt;

    // Advance chain from the output backwards: a stage may leave if the next one is
    // empty or is itself leaving this cycle
    always_comb begin
        w_adv         = '0;
        w_adv[STG_SV] = w_done[STG_SV] && out_ready;
        w_adv[STG_SM] = w_done[STG_SM] && (!w_busy[STG_SV] || w_adv[STG_SV]);
        w_adv[STG_QK] = w_done[STG_QK] && (!w_busy[STG_SM] || w_adv[STG_SM]);
        in_ready      = !w_busy[STG_QK] || w_adv[STG_QK];
        w_accept      = in_valid && in_ready;
    end

    // Load enables share the edge with the occupancy update of the receiving slot
    always_comb begin
        stage_en         = '0;
        stage_en[STG_QK] = w_accept;
        stage_en[STG_SM] = w_adv[STG_QK];
        stage_en[STG_SV] = w_adv[STG_SM];
    end

    attn_stage_slot #(
        .LAT (LAT_QK),
        .CW  (CW)
    ) u_slot_qk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (stage_en[STG_QK]),
        .i_adv  (w_adv[STG_QK]),
        .o_busy (w_busy[STG_QK]),
        .o_done (w_done[STG_QK])
    );

    attn_stage_slot #(
        .LAT (LAT_SM),
        .CW  (CW)
    ) u_slot_sm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (stage_en[STG_SM]),
        .i_adv  (w_adv[STG_SM]),
        .o_busy (w_busy[STG_SM]),
        .o_done (w_done[STG_SM])
    );

    attn_stage_slot #(
        .LAT (LAT_SV),
        .CW  (CW)
    ) u_slot_sv (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (stage_en[STG_SV]),
        .i_adv  (w_adv[STG_SV]),
        .o_busy (w_busy[STG_SV]),
        .o_done (w_done[STG_SV])
    );

    // Completed-job counter, wraps naturally at 2^CNT_WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_cnt <= '0;
        end else if (w_adv[STG_SV]) begin
            r_job_cnt <= r_job_cnt + CNT_WIDTH'(1);
        end
    end

    assign out_valid  = w_done[STG_SV];
    assign stage_busy = w_busy;
    assign idle       = (w_busy == '0);
    assign job_cnt    = r_job_cnt;

endmodule

// File: tb/tb_attn_pipe_ctrl.sv
// Bench for attn_pipe_ctrl: two instances (latencies 1/4/1 with a 4-bit job counter,
// and 1/1/1 with a 16-bit counter) driven by the same stimulus and compared every
// cycle against a job-level reference model that tracks the cycle each job finishes.
module tb_attn_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid;
    logic out_ready;

    logic        a_in_ready, a_out_valid, a_idle;
    logic [2:0]  a_stage_en, a_stage_busy;
    logic [3:0]  a_job_cnt;
    logic        b_in_ready, b_out_valid, b_idle;
    logic [2:0]  b_stage_en, b_stage_busy;
    logic [15:0] b_job_cnt;

    attn_pipe_ctrl #(
        .LAT_QK    (1),
        .LAT_SM    (4),
        .LAT_SV    (1),
        .CNT_WIDTH (4)
    ) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .stage_en   (a_stage_en),
        .stage_busy (a_stage_busy),
        .job_cnt    (a_job_cnt),
        .idle       (a_idle)
    );

    attn_pipe_ctrl #(
        .LAT_QK    (1),
        .LAT_SM    (1),
        .LAT_SV    (1),
        .CNT_WIDTH (16)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .stage_en   (b_stage_en),
        .stage_busy (b_stage_busy),
        .job_cnt    (b_job_cnt),
        .idle       (b_idle)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per instance, per stage, whether a job is held and the
    // absolute cycle at which its computation finishes
    int lat   [2][3];
    bit m_occ [2][3];
    int m_rdy [2][3];
    int m_cnt [2];
    bit m_done[2][3];
    bit m_adv [2][3];
    bit m_inr [2];
    bit m_acc [2];
    int cyc;
    int acc_a;
    int seen110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            for (int k = 0; k < 3; k++) m_occ[d][k] = 1'b0;
        end
    endfunction

    function automatic void model_comb();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) m_done[d][k] = m_occ[d][k] && (cyc >= m_rdy[d][k]);
            m_adv[d][2] = m_done[d][2] && out_ready;
            m_adv[d][1] = m_done[d][1] && (!m_occ[d][2] || m_adv[d][2]);
            m_adv[d][0] = m_done[d][0] && (!m_occ[d][1] || m_adv[d][1]);
            m_inr[d]    = !m_occ[d][0] || m_adv[d][0];
            m_acc[d]    = in_valid && m_inr[d];
        end
    endfunction

    function automatic void model_edge();
        bit ent;
        for (int d = 0; d < 2; d++) begin
            if (m_adv[d][2]) m_cnt[d]++;
            for (int k = 0; k < 3; k++) begin
                if (k == 0) ent = m_acc[d];
                else        ent = m_adv[d][k-1];
                if (ent) begin
                    m_occ[d][k] = 1'b1;
                    m_rdy[d][k] = cyc + lat[d][k];
                end else if (m_adv[d][k]) begin
                    m_occ[d][k] = 1'b0;
                end
            end
        end
        cyc++;
    endfunction

    task automatic compare_all();
        logic [2:0] busy, en;
        for (int d = 0; d < 2; d++) begin
            busy = {m_occ[d][2], m_occ[d][1], m_occ[d][0]};
            en   = {m_adv[d][1], m_adv[d][0], m_acc[d]};
            if (d == 0) begin
                chk("a_in_ready",   32'(a_in_ready),   32'(m_inr[0]));
                chk("a_out_valid",  32'(a_out_valid),  32'(m_done[0][2]));
                chk("a_stage_en",   32'(a_stage_en),   32'(en));
                chk("a_stage_busy", 32'(a_stage_busy), 32'(busy));
                chk("a_idle",       32'(a_idle),       32'(busy == 3'b000));
                chk("a_job_cnt",    32'(a_job_cnt),    32'(m_cnt[0] % 16));
            end else begin
                chk("b_in_ready",   32'(b_in_ready),   32'(m_inr[1]));
                chk("b_out_valid",  32'(b_out_valid),  32'(m_done[1][2]));
                chk("b_stage_en",   32'(b_stage_en),   32'(en));
                chk("b_stage_busy", 32'(b_stage_busy), 32'(busy));
                chk("b_idle",       32'(b_idle),       32'(busy == 3'b000));
                chk("b_job_cnt",    32'(b_job_cnt),    32'(m_cnt[1] % 65536));
            end
        end
    endtask

    // One clock: compare mid-cycle, then advance the model on the rising edge
    task automatic step();
        @(negedge clk);
        model_comb();
        compare_all();
        if (m_acc[0]) acc_a++;
        if (a_stage_en === 3'b110) seen110++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_busy"},  32'(a_stage_busy), 32'h0);
        chk({tag, "_a_ov"},    32'(a_out_valid),  32'h0);
        chk({tag, "_a_cnt"},   32'(a_job_cnt),    32'h0);
        chk({tag, "_a_ir"},    32'(a_in_ready),   32'h1);
        chk({tag, "_a_idle"},  32'(a_idle),       32'h1);
        chk({tag, "_b_busy"},  32'(b_stage_busy), 32'h0);
        chk({tag, "_b_ov"},    32'(b_out_valid),  32'h0);
        chk({tag, "_b_cnt"},   32'(b_job_cnt),    32'h0);
        chk({tag, "_b_ir"},    32'(b_in_ready),   32'h1);
        chk({tag, "_b_idle"},  32'(b_idle),       32'h1);
    endtask

    initial begin
        int guard;
        lat[0][0] = 1; lat[0][1] = 4; lat[0][2] = 1;
        lat[1][0] = 1; lat[1][1] = 1; lat[1][2] = 1;
        cyc       = 0;
        acc_a     = 0;
        seen110   = 0;
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk_reset_state("reset");
        chk("reset_a_en", 32'(a_stage_en), 32'h0);
        chk("reset_b_en", 32'(b_stage_en), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single job through both pipelines
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        chk("single_a_cnt",  32'(a_job_cnt), 32'd1);
        chk("single_b_cnt",  32'(b_job_cnt), 32'd1);
        chk("single_a_idle", 32'(a_idle),    32'd1);

        // Streaming with in_valid and out_ready held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (10) step();
        in_valid = 1'b0;
        repeat (10) step();
        chk("stream_b_cnt", 32'(b_job_cnt), 32'd11);

        // Backpressure: fill all stages, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (12) step();
        chk("bp_a_busy", 32'(a_stage_busy), 32'h7);
        chk("bp_a_ir",   32'(a_in_ready),   32'h0);
        chk("bp_b_busy", 32'(b_stage_busy), 32'h7);
        chk("bp_b_ir",   32'(b_in_ready),   32'h0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        chk("bp_b_cnt",  32'(b_job_cnt), 32'd15);
        chk("bp_a_idle", 32'(a_idle),    32'd1);

        // Random traffic
        repeat (300) begin
            in_valid  = 1'($urandom % 2);
            out_ready = (($urandom % 4) != 0);
            step();
        end

        // Reset with jobs in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (4) step();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        chk_reset_state("midrst");
        @(posedge clk);
        #1;
        chk_reset_state("midrst_hold");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // Counter wrap: 17 jobs through the 4-bit instance
        acc_a    = 0;
        guard    = 0;
        in_valid = 1'b1;
        while (acc_a < 17 && guard < 500) begin
            step();
            guard++;
        end
        in_valid = 1'b0;
        repeat (12) step();
        chk("wrap_a_cnt",  32'(a_job_cnt), 32'd1);
        chk("wrap_a_idle", 32'(a_idle),    32'd1);

        chk("same_cycle_adv_seen", 32'(seen110 != 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
